// File: rtl/dac_sample_player.sv
// -----------------------------------------------------------------------------
// dac_sample_player
//
// Purpose:
//   Reads 32-bit words from the DDR3->playback FIFO and unpacks each word into
//   four unsigned 8-bit samples (byte0 = word[7:0] first). The samples are paced
//   out at one per (rate_div+1) clocks as a 12-bit DAC amplitude {byte,4'b0000}.
//   The FIFO runs in standard mode: data appears one cycle after fifo_rd_en.
//   One shadow word is prefetched during playback so that the output can run
//   without gaps when rate_div >= 2.
//
// Ports:
//   clk          in   system clock (FIFO read side and DAC share it)
//   reset        in   asynchronous, active-high reset
//   start        in   1-cycle pulse; starts playback when idle
//   stop         in   1-cycle pulse; aborts playback; wins over start
//   num_samples  in   [CNT_W] number of samples to play, latched on start
//   rate_div     in   [DIV_W] sample period minus one, latched on start
//   fifo_dout    in   [32] FIFO read data, valid the cycle after fifo_rd_en
//   fifo_empty   in   FIFO empty flag
//   fifo_rd_en   out  FIFO read strobe, never asserted while fifo_empty=1
//   ampl         out  [12] DAC amplitude; 12'h800 when idle
//   ampl_valid   out  1-cycle pulse per new sample on ampl
//   busy         out  high in every state except IDLE
//   done         out  1-cycle pulse after the last sample has been emitted
//   underrun     out  sticky missed-tick flag, cleared on an accepted start
//
// Optional feature (macro DAC_PLAYER_UNDERRUN_CNT_EN):
//   adds output underrun_cnt[15:0], a saturating count of missed ticks that
//   clears on reset and on an accepted start.
// -----------------------------------------------------------------------------
module dac_sample_player #(
   parameter int CNT_W = 24,
   parameter int DIV_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             stop,
   input  logic [CNT_W-1:0] num_samples,
   input  logic [DIV_W-1:0] rate_div,
   input  logic [31:0]      fifo_dout,
   input  logic             fifo_empty,
   output logic             fifo_rd_en,
   output logic [11:0]      ampl,
   output logic             ampl_valid,
   output logic             busy,
   output logic             done,
   output logic             underrun
`ifdef DAC_PLAYER_UNDERRUN_CNT_EN
   ,
   output logic [15:0]      underrun_cnt
`endif
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_PRIME = 2'd1,
      S_PLAY  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   localparam logic [11:0] AMPL_IDLE = 12'h800;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic [DIV_W-1:0] tick_q, tick_d;
   logic [31:0]      cur_q, cur_d;
   logic [31:0]      sh_q, sh_d;
   logic             cur_vld_q, cur_vld_d;
   logic             sh_vld_q, sh_vld_d;
   logic [1:0]       idx_q, idx_d;
   logic             rd_pend_q;
   logic [11:0]      ampl_q, ampl_d;
   logic             ampl_valid_q, ampl_valid_d;
   logic             done_q, done_d;
   logic             underrun_q, underrun_d;
`ifdef DAC_PLAYER_UNDERRUN_CNT_EN
   logic [15:0]      ucnt_q, ucnt_d;
`endif

   logic             tick_zero;
   logic             emit;
   logic             miss;
   logic             last_emit;
   logic [2:0]       bytes_left;
   logic [7:0]       cur_byte;
   logic [7:0]       emit_byte;

   // A tick is only acted on in PLAY and never in the cycle stop aborts.
   assign tick_zero  = (state_q == S_PLAY) && (tick_q == '0) && !stop;
   // A word landing from the FIFO this cycle can be emitted directly, so a
   // stalled tick resolves in the very cycle the data arrives.
   assign emit       = tick_zero && (cur_vld_q || rd_pend_q);
   assign miss       = tick_zero && !cur_vld_q && !rd_pend_q;
   assign last_emit  = emit && (cnt_q == CNT_W'(1));
   assign bytes_left = cur_vld_q ? (3'd4 - {1'b0, idx_q}) : 3'd0;

   always_comb begin
      case (idx_q)
         2'd0:    cur_byte = cur_q[7:0];
         2'd1:    cur_byte = cur_q[15:8];
         2'd2:    cur_byte = cur_q[23:16];
         default: cur_byte = cur_q[31:24];
      endcase
   end

   assign emit_byte = cur_vld_q ? cur_byte : fifo_dout[7:0];

   // FSM: state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   // FSM: next state
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: begin
            if (start && !stop && (num_samples != '0)) state_d = S_PRIME;
         end
         S_PRIME: begin
            if (stop)           state_d = S_IDLE;
            else if (rd_pend_q) state_d = S_PLAY;
         end
         S_PLAY: begin
            if (stop)           state_d = S_IDLE;
            else if (last_emit) state_d = S_DONE;
         end
         S_DONE: state_d = S_IDLE;
      endcase
   end

   // FSM: outputs. Every read is gated by !fifo_empty and only one read is
   // ever in flight, which keeps the shadow register from being overrun.
   always_comb begin
      fifo_rd_en = 1'b0;
      busy       = (state_q != S_IDLE);
      unique case (state_q)
         S_PRIME: fifo_rd_en = !stop && !rd_pend_q && !fifo_empty;
         S_PLAY:  fifo_rd_en = !stop && !rd_pend_q && !fifo_empty && !sh_vld_q &&
                               (cnt_q > CNT_W'(bytes_left));
         default: fifo_rd_en = 1'b0;
      endcase
   end

   // Datapath next state
   always_comb begin
      cnt_d        = cnt_q;
      div_d        = div_q;
      tick_d       = tick_q;
      cur_d        = cur_q;
      cur_vld_d    = cur_vld_q;
      sh_d         = sh_q;
      sh_vld_d     = sh_vld_q;
      idx_d        = idx_q;
      ampl_d       = ampl_q;
      ampl_valid_d = 1'b0;
      done_d       = 1'b0;
      underrun_d   = underrun_q;
`ifdef DAC_PLAYER_UNDERRUN_CNT_EN
      ucnt_d       = ucnt_q;
`endif
      unique case (state_q)
         S_IDLE: begin
            if (start && !stop) begin
               underrun_d = 1'b0;
`ifdef DAC_PLAYER_UNDERRUN_CNT_EN
               ucnt_d     = '0;
`endif
               if (num_samples == '0) begin
                  done_d = 1'b1;
               end else begin
                  cnt_d     = num_samples;
                  div_d     = rate_div;
                  tick_d    = '0;
                  cur_vld_d = 1'b0;
                  sh_vld_d  = 1'b0;
                  idx_d     = '0;
               end
            end
         end
         S_PRIME: begin
            // tick starts at 0 so the first sample goes out in the first PLAY cycle
            if (!stop && rd_pend_q) begin
               cur_d     = fifo_dout;
               cur_vld_d = 1'b1;
               idx_d     = '0;
               tick_d    = '0;
            end
         end
         S_PLAY: begin
            if (!stop) begin
               // Landing data fills the shadow when a current word exists,
               // otherwise it becomes the current word directly.
               if (rd_pend_q) begin
                  if (cur_vld_q) begin
                     sh_d     = fifo_dout;
                     sh_vld_d = 1'b1;
                  end else begin
                     cur_d     = fifo_dout;
                     cur_vld_d = 1'b1;
                     idx_d     = '0;
                  end
               end
               if (tick_q != '0) begin
                  tick_d = tick_q - DIV_W'(1);
               end else if (emit) begin
                  ampl_d       = {emit_byte, 4'b0000};
                  ampl_valid_d = 1'b1;
                  tick_d       = div_q;
                  cnt_d        = cnt_q - CNT_W'(1);
                  done_d       = last_emit;
                  if (!cur_vld_q) begin
                     // byte0 of the landing word was just used
                     cur_d     = fifo_dout;
                     cur_vld_d = 1'b1;
                     idx_d     = 2'd1;
                  end else if (idx_q == 2'd3) begin
                     // Word exhausted: promote the shadow, or a word landing now.
                     cur_d     = sh_vld_q ? sh_q : fifo_dout;
                     cur_vld_d = sh_vld_q || rd_pend_q;
                     sh_vld_d  = 1'b0;
                     idx_d     = '0;
                  end else begin
                     idx_d = idx_q + 2'd1;
                  end
               end else if (miss) begin
                  // tick_q stays at 0 so the sample goes out once data lands
                  underrun_d = 1'b1;
`ifdef DAC_PLAYER_UNDERRUN_CNT_EN
                  if (ucnt_q != 16'hFFFF) ucnt_d = ucnt_q + 16'd1;
`endif
               end
            end
         end
         S_DONE: ampl_d = AMPL_IDLE;
      endcase
      if (stop && (state_q != S_IDLE)) ampl_d = AMPL_IDLE;
   end

   // Datapath registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q        <= '0;
         div_q        <= '0;
         tick_q       <= '0;
         cur_q        <= '0;
         cur_vld_q    <= 1'b0;
         sh_q         <= '0;
         sh_vld_q     <= 1'b0;
         idx_q        <= '0;
         rd_pend_q    <= 1'b0;
         ampl_q       <= AMPL_IDLE;
         ampl_valid_q <= 1'b0;
         done_q       <= 1'b0;
         underrun_q   <= 1'b0;
`ifdef DAC_PLAYER_UNDERRUN_CNT_EN
         ucnt_q       <= '0;
`endif
      end else begin
         cnt_q        <= cnt_d;
         div_q        <= div_d;
         tick_q       <= tick_d;
         cur_q        <= cur_d;
         cur_vld_q    <= cur_vld_d;
         sh_q         <= sh_d;
         sh_vld_q     <= sh_vld_d;
         idx_q        <= idx_d;
         rd_pend_q    <= fifo_rd_en;
         ampl_q       <= ampl_d;
         ampl_valid_q <= ampl_valid_d;
         done_q       <= done_d;
         underrun_q   <= underrun_d;
`ifdef DAC_PLAYER_UNDERRUN_CNT_EN
         ucnt_q       <= ucnt_d;
`endif
      end
   end

   assign ampl       = ampl_q;
   assign ampl_valid = ampl_valid_q;
   assign done       = done_q;
   assign underrun   = underrun_q;
`ifdef DAC_PLAYER_UNDERRUN_CNT_EN
   assign underrun_cnt = ucnt_q;
`endif

endmodule

// File: tb/tb_dac_sample_player.sv
// -----------------------------------------------------------------------------
// tb_dac_sample_player
// Scoreboard bench: the expected sample stream is derived from the FIFO word
// contents (bytes in little-endian order, truncated to num_samples) and queued
// when a playback is started; a monitor pops and compares each ampl_valid.
// -----------------------------------------------------------------------------
module tb_dac_sample_player;

   localparam int CNT_W = 24;
   localparam int DIV_W = 16;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             start = 1'b0;
   logic             stop = 1'b0;
   logic [CNT_W-1:0] num_samples = '0;
   logic [DIV_W-1:0] rate_div = '0;
   logic [31:0]      fifo_dout = '0;
   logic             fifo_empty = 1'b1;
   logic             fifo_rd_en;
   logic [11:0]      ampl;
   logic             ampl_valid;
   logic             busy;
   logic             done;
   logic             underrun;
`ifdef DAC_PLAYER_UNDERRUN_CNT_EN
   logic [15:0]      underrun_cnt;
`endif

   always #5 clk = ~clk;

   dac_sample_player #(.CNT_W(CNT_W), .DIV_W(DIV_W)) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .stop        (stop),
      .num_samples (num_samples),
      .rate_div    (rate_div),
      .fifo_dout   (fifo_dout),
      .fifo_empty  (fifo_empty),
      .fifo_rd_en  (fifo_rd_en),
      .ampl        (ampl),
      .ampl_valid  (ampl_valid),
      .busy        (busy),
      .done        (done),
      .underrun    (underrun)
`ifdef DAC_PLAYER_UNDERRUN_CNT_EN
      ,
      .underrun_cnt(underrun_cnt)
`endif
   );

   typedef struct packed {
      logic [11:0] a;
      int          gap;   // required spacing from previous sample; 0 = not checked
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] fifo_q[$];
   logic [31:0] txn_w[$];

   int checks = 0;
   int errors = 0;
   int mcyc = 0, last_vld = 0, vld_cnt = 0, done_cnt = 0;
   int rd_cnt = 0, rd_viol = 0;

   function automatic void chk(string name, longint act, longint req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
      end
   endfunction

   // FIFO model: standard mode, data one cycle after the read strobe.
   initial forever begin
      @(posedge clk);
      if (fifo_rd_en) begin
         rd_cnt++;
         if (fifo_empty) rd_viol++;
         if (fifo_q.size() > 0) fifo_dout <= fifo_q.pop_front();
      end
      fifo_empty <= (fifo_q.size() == 0);
   end

   // Monitor
   initial forever begin
      exp_t e;
      @(negedge clk);
      mcyc++;
      if (done) done_cnt++;
      if (ampl_valid) begin
         vld_cnt++;
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_sample: got %0h expected no sample", ampl);
         end else begin
            e = exp_q.pop_front();
            chk("ampl", ampl, e.a);
            if (e.gap > 0) chk("gap", mcyc - last_vld, e.gap);
         end
         last_vld = mcyc;
      end
   end

   // Expected stream from txn_w: bytes in order, first n; gap 0 at the first
   // sample and at index skip_idx (used where an underrun stalls output).
   task automatic expect_stream(input int n, input int rd, input int skip_idx);
      logic [7:0] bytes[$];
      exp_t e;
      bytes = {};
      foreach (txn_w[i])
         for (int b = 0; b < 4; b++) bytes.push_back(txn_w[i][8*b +: 8]);
      for (int s = 0; s < n; s++) begin
         e.a   = {bytes[s], 4'h0};
         e.gap = (s == 0 || s == skip_idx) ? 0 : rd + 1;
         exp_q.push_back(e);
      end
   endtask

   task automatic pulse_start(input int n, input int rd);
      num_samples = CNT_W'(n);
      rate_div    = DIV_W'(rd);
      start       = 1'b1;
      @(negedge clk);
      start       = 1'b0;
   endtask

   task automatic wait_done(input int d0, input int inject_at, input string tag);
      int k = 0;
      while (done_cnt == d0 && k < 2000) begin
         if (inject_at > 0 && k == inject_at) begin
            num_samples = CNT_W'(1);
            rate_div    = DIV_W'(7);
            start       = 1'b1;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
         k++;
      end
      start = 1'b0;
      chk({tag, "_no_timeout"}, (k < 2000), 1);
      repeat (3) @(negedge clk);
   endtask

   task automatic play(input int n, input int rd, input int exp_reads,
                       input int inject_at, input string tag);
      int rd0, d0;
      expect_stream(n, rd, -1);
      foreach (txn_w[i]) fifo_q.push_back(txn_w[i]);
      rd0 = rd_cnt;
      d0  = done_cnt;
      pulse_start(n, rd);
      wait_done(d0, inject_at, tag);
      chk({tag, "_done_count"}, done_cnt - d0, 1);
      chk({tag, "_reads"}, rd_cnt - rd0, exp_reads);
      chk({tag, "_all_samples"}, exp_q.size(), 0);
      chk({tag, "_busy_after"}, busy, 0);
      chk({tag, "_ampl_idle"}, ampl, 12'h800);
      chk({tag, "_underrun"}, underrun, 0);
      exp_q.delete();
      fifo_q.delete();
   endtask

   initial begin
      int rd0, d0, v0, n, rd;
      // 1: reset
      repeat (3) @(negedge clk);
      chk("rst_ampl", ampl, 12'h800);
      reset = 1'b0;
      @(negedge clk);
      chk("rst_ampl_after", ampl, 12'h800);
      chk("rst_busy", busy, 0);
      chk("rst_rd_en", fifo_rd_en, 0);
      chk("rst_valid", ampl_valid, 0);
      chk("rst_done", done, 0);
      chk("rst_underrun", underrun, 0);

      // 2: two full words
      txn_w = {32'h44332211, 32'h88776655};
      play(8, 3, 2, 0, "t2");

      // 3: six samples, last two bytes discarded
      play(6, 3, 2, 0, "t3");

      // 4: underrun while the second word is late
      txn_w = {32'h44332211, 32'h88776655};
      expect_stream(8, 3, 4);
      fifo_q.push_back(32'h44332211);
      rd0 = rd_cnt;
      d0  = done_cnt;
      pulse_start(8, 3);
      repeat (21) @(negedge clk);
      chk("t4_ampl_hold", ampl, 12'h440);
      chk("t4_underrun_set", underrun, 1);
      chk("t4_busy", busy, 1);
      fifo_q.push_back(32'h88776655);
      wait_done(d0, 0, "t4");
      chk("t4_done_count", done_cnt - d0, 1);
      chk("t4_reads", rd_cnt - rd0, 2);
      chk("t4_all_samples", exp_q.size(), 0);
      chk("t4_underrun_sticky", underrun, 1);
`ifdef DAC_PLAYER_UNDERRUN_CNT_EN
      chk("t4_underrun_cnt_nonzero", (underrun_cnt != 16'd0), 1);
`endif
      exp_q.delete();
      fifo_q.delete();

      // 5: stop after two samples, then a fresh playback
      txn_w = {32'h44332211, 32'h88776655};
      expect_stream(8, 3, -1);
      foreach (txn_w[i]) fifo_q.push_back(txn_w[i]);
      d0 = done_cnt;
      v0 = vld_cnt;
      pulse_start(8, 3);
      for (int k = 0; k < 200 && vld_cnt < v0 + 2; k++) @(negedge clk);
      chk("t5_two_samples", vld_cnt - v0, 2);
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
      chk("t5_busy_after_stop", busy, 0);
      chk("t5_ampl_after_stop", ampl, 12'h800);
      exp_q.delete();
      v0 = vld_cnt;
      repeat (12) @(negedge clk);
      chk("t5_no_done", done_cnt - d0, 0);
      chk("t5_no_more_samples", vld_cnt - v0, 0);
      fifo_q.delete();
      txn_w = {32'hDEADBEEF, 32'h0F1E2D3C};
      play(5, 2, 2, 0, "t5b");

      // 6: zero samples, and start+stop together
      rd0 = rd_cnt;
      d0  = done_cnt;
      num_samples = '0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("t6_done_pulse", done, 1);
      chk("t6_busy", busy, 0);
      @(negedge clk);
      chk("t6_done_one_cycle", done, 0);
      fifo_q.push_back(32'h12345678);
      num_samples = CNT_W'(4);
      start = 1'b1;
      stop  = 1'b1;
      @(negedge clk);
      start = 1'b0;
      stop  = 1'b0;
      chk("t6_start_stop_busy", busy, 0);
      repeat (4) @(negedge clk);
      chk("t6_reads", rd_cnt - rd0, 0);
      chk("t6_done_count", done_cnt - d0, 1);
      fifo_q.delete();
      repeat (2) @(negedge clk);

      // 7: start while busy is ignored
      txn_w = {32'hA1B2C3D4, 32'h55AA33CC};
      play(8, 2, 2, 5, "t7");

      // random playbacks
      for (int t = 0; t < 8; t++) begin
         n  = $urandom_range(1, 12);
         rd = $urandom_range(2, 5);
         txn_w = {};
         for (int w = 0; w < (n + 3) / 4; w++) txn_w.push_back($urandom);
         play(n, rd, (n + 3) / 4, 0, "rnd");
      end

      // asynchronous reset in the middle of playback
      txn_w = {32'h44332211, 32'h88776655};
      expect_stream(8, 3, -1);
      foreach (txn_w[i]) fifo_q.push_back(txn_w[i]);
      pulse_start(8, 3);
      repeat (9) @(negedge clk);
      chk("mr_busy_before", busy, 1);
      @(posedge clk);
      #2 reset = 1'b1;
      #1;
      chk("mr_ampl", ampl, 12'h800);
      chk("mr_busy", busy, 0);
      chk("mr_valid", ampl_valid, 0);
      chk("mr_rd_en", fifo_rd_en, 0);
      exp_q.delete();
      fifo_q.delete();
      @(negedge clk);
      reset = 1'b0;
      repeat (2) @(negedge clk);

      chk("rd_en_while_empty", rd_viol, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
